// File: rtl/priority_encoder_if.sv
// Request/result bundle for the priority encoder.
// The master drives the request vector. The slave (the encoder) returns the winning index and the valid flag.
interface priority_encoder_if #(
  parameter int DATA_W = 3,
  parameter int OUT_W  = 2
);
  logic [DATA_W-1:0] data_in_i;
  logic [OUT_W-1:0]  data_out_o;
  logic              valid_o;

  modport master (output data_in_i, input data_out_o, input valid_o);
  modport slave  (input data_in_i, output data_out_o, output valid_o);
endinterface

// File: rtl/priority_encoder.sv
// Registered N-input priority encoder.
// It reports the index of the winning request bit together with a valid flag.
// An all-zero request gives index 0 with valid low, so consumers must qualify the index with valid.
module priority_encoder #(
  parameter int DATA_W    = 3,
  parameter int OUT_W     = 2,
  parameter int MSB_FIRST = 1,
  parameter int REG_OUT   = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  priority_encoder_if.slave bus
);

  // Scan so that the winning bit is the last one written.
  // Indices only ever come from real bit positions, so codes >= DATA_W never appear.
  function automatic logic [OUT_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [OUT_W-1:0] idx;
    idx = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (d[i]) idx = OUT_W'(i);
      end
    end else begin
      for (int i = DATA_W - 1; i >= 0; i--) begin
        if (d[i]) idx = OUT_W'(i);
      end
    end
    return idx;
  endfunction

  logic [OUT_W-1:0] w_idx_p0;
  logic             w_vld_p0;

  // Stage p0: combinational encode of the current request vector.
  always_comb begin
    w_idx_p0 = encode(bus.data_in_i);
    w_vld_p0 = |bus.data_in_i;
  end

  if (REG_OUT != 0) begin : g_reg
    logic [OUT_W-1:0] r_idx_p1;
    logic             r_vld_p1;

    // Stage p1: output register.
    // Reset clears both the index and the flag, so outputs read zero immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_idx_p1 <= '0;
        r_vld_p1 <= 1'b0;
      end else begin
        r_idx_p1 <= w_idx_p0;
        r_vld_p1 <= w_vld_p0;
      end
    end

    assign bus.data_out_o = r_idx_p1;
    assign bus.valid_o    = r_vld_p1;
  end else begin : g_comb
    // Unregistered path: reset still masks the outputs to zero.
    assign bus.data_out_o = rst_n_i ? w_idx_p0 : '0;
    assign bus.valid_o    = rst_n_i & w_vld_p0;
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Bench for priority_encoder.
// It exercises the default MSB-first registered encoder, an LSB-first variant, an 8-bit-wide variant and a combinational variant.
module tb_priority_encoder;

  logic clk;
  logic rst_n;

  int n_vec = 0;
  int n_bad = 0;

  priority_encoder_if #(.DATA_W(3), .OUT_W(2)) if_msb ();
  priority_encoder_if #(.DATA_W(3), .OUT_W(2)) if_lsb ();
  priority_encoder_if #(.DATA_W(8), .OUT_W(3)) if_w8 ();
  priority_encoder_if #(.DATA_W(3), .OUT_W(2)) if_cmb ();

  priority_encoder #(.DATA_W(3), .OUT_W(2), .MSB_FIRST(1), .REG_OUT(1))
    dut (.clk_i(clk), .rst_n_i(rst_n), .bus(if_msb));
  priority_encoder #(.DATA_W(3), .OUT_W(2), .MSB_FIRST(0), .REG_OUT(1))
    dut_lsb (.clk_i(clk), .rst_n_i(rst_n), .bus(if_lsb));
  priority_encoder #(.DATA_W(8), .OUT_W(3), .MSB_FIRST(1), .REG_OUT(1))
    dut_w8 (.clk_i(clk), .rst_n_i(rst_n), .bus(if_w8));
  priority_encoder #(.DATA_W(3), .OUT_W(2), .MSB_FIRST(1), .REG_OUT(0))
    dut_cmb (.clk_i(clk), .rst_n_i(rst_n), .bus(if_cmb));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference: position of the highest set bit, computed as floor(log2(v)); 0 when v is 0.
  function automatic int ref_msb(input int v);
    int x;
    int n;
    x = v;
    n = 0;
    while (x > 1) begin
      x = x / 2;
      n++;
    end
    return n;
  endfunction

  // Reference: position of the lowest set bit, found by isolating it with v & -v.
  function automatic int ref_lsb(input int v);
    if (v == 0) return 0;
    return ref_msb(v & -v);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge.
  // Check the combinational copy before the next rising edge and the registered copies just after it.
  task automatic step(input string tag, input logic [2:0] d3, input logic [7:0] d8);
    @(negedge clk);
    if_msb.data_in_i = d3;
    if_lsb.data_in_i = d3;
    if_cmb.data_in_i = d3;
    if_w8.data_in_i  = d8;
    #1;
    check({tag, " cmb idx"}, 8'(if_cmb.data_out_o), 8'(ref_msb(int'(d3))));
    check({tag, " cmb vld"}, 8'(if_cmb.valid_o), 8'(d3 != 0));
    @(posedge clk);
    #1;
    check({tag, " msb idx"}, 8'(if_msb.data_out_o), 8'(ref_msb(int'(d3))));
    check({tag, " msb vld"}, 8'(if_msb.valid_o), 8'(d3 != 0));
    check({tag, " lsb idx"}, 8'(if_lsb.data_out_o), 8'(ref_lsb(int'(d3))));
    check({tag, " lsb vld"}, 8'(if_lsb.valid_o), 8'(d3 != 0));
    check({tag, " w8 idx"},  8'(if_w8.data_out_o), 8'(ref_msb(int'(d8))));
    check({tag, " w8 vld"},  8'(if_w8.valid_o), 8'(d8 != 0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " msb idx"}, 8'(if_msb.data_out_o), 8'd0);
    check({tag, " msb vld"}, 8'(if_msb.valid_o), 8'd0);
    check({tag, " lsb idx"}, 8'(if_lsb.data_out_o), 8'd0);
    check({tag, " lsb vld"}, 8'(if_lsb.valid_o), 8'd0);
    check({tag, " w8 idx"},  8'(if_w8.data_out_o), 8'd0);
    check({tag, " w8 vld"},  8'(if_w8.valid_o), 8'd0);
    check({tag, " cmb idx"}, 8'(if_cmb.data_out_o), 8'd0);
    check({tag, " cmb vld"}, 8'(if_cmb.valid_o), 8'd0);
  endtask

  initial begin
    logic [2:0] r3;
    logic [7:0] r8;

    // Reset held with all requests set: everything must stay zero across edges.
    rst_n = 1'b0;
    if_msb.data_in_i = 3'b111;
    if_lsb.data_in_i = 3'b111;
    if_cmb.data_in_i = 3'b111;
    if_w8.data_in_i  = 8'hFF;
    #5;
    check_all_zero("reset early");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset held");
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep all 3-bit codes, one per clock period.
    // The 8-bit copy gets a walking pattern at the same time.
    for (int v = 0; v < 8; v++) begin
      step("sweep", 3'(v), 8'(1 << v));
    end

    // Priority case, plus the wide-input example.
    step("prio", 3'b101, 8'b0100_0001);

    // Back-to-back changes on consecutive cycles with no bubbles.
    step("b2b0", 3'b001, 8'h80);
    step("b2b1", 3'b100, 8'h03);
    step("b2b2", 3'b010, 8'h00);
    step("b2b3", 3'b000, 8'h10);

    // Asynchronous reset pulse between edges with the input held at 100.
    step("pre rst", 3'b100, 8'b0100_0001);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async rst");
    #3;
    rst_n = 1'b1;
    #1;
    check("post rel msb idx", 8'(if_msb.data_out_o), 8'd0);
    check("post rel msb vld", 8'(if_msb.valid_o), 8'd0);
    check("post rel cmb idx", 8'(if_cmb.data_out_o), 8'd2);
    check("post rel cmb vld", 8'(if_cmb.valid_o), 8'd1);
    @(posedge clk);
    #1;
    check("recover msb idx", 8'(if_msb.data_out_o), 8'd2);
    check("recover msb vld", 8'(if_msb.valid_o), 8'd1);
    check("recover w8 idx",  8'(if_w8.data_out_o), 8'd6);
    check("recover w8 vld",  8'(if_w8.valid_o), 8'd1);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 60; k++) begin
      r3 = 3'($urandom_range(0, 7));
      r8 = 8'($urandom_range(0, 255));
      step("rand", r3, r8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
